reconf_seq: RTL and testbench
=============================

RECONF_SEQ -- requirements
Module: reconf_seq

Interface
REQ-001 Parameter NUM_REGS, default 2, SHALL set the number of DRP registers rewritten per reconfiguration (legal range 1-8).
REQ-002 Parameter ADDR_TABLE, default 56'h0, SHALL hold 8 packed 7-bit DRP addresses; entry i occupies bits [7i+6:7i].
REQ-003 Parameter MASK_TABLE, default 128'h0, SHALL hold 8 packed 16-bit masks; entry i occupies bits [16i+15:16i]; mask bit 1 = keep the read-back bit.
REQ-004 Parameter DATA_TABLE, default 128'h0, SHALL hold 8 packed 16-bit new values, packed like MASK_TABLE.
REQ-005 Parameter DRDY_TIMEOUT, default 16, SHALL be the maximum cycles spent waiting for DRDY.
REQ-006 Parameter LOCK_TIMEOUT, default 4096, SHALL be the maximum cycles spent waiting for LOCKED.
REQ-007 DCLK  in  1  sole clock; all logic is clocked on its rising edge.
REQ-008 RSTN  in  1  synchronous, active-low reset.
REQ-009 SEN  in  1  start request, sampled every cycle.
REQ-010 SRDY  out  1  one-cycle pulse: reconfiguration finished and PLL locked.
REQ-011 BUSY  out  1  high from start acceptance until SRDY or ERR.
REQ-012 ERR  out  1  sticky flag: DRDY or lock timeout.
REQ-013 PLL_RST  out  1  drives the PLL RST input.
REQ-014 LOCKED  in  1  PLL LOCKED output.
REQ-015 DADDR  out  7 / DEN  out  1 / DWE  out  1 / DI  out  16: DRP request to the PLL.
REQ-016 DO  in  16 / DRDY  in  1: DRP response from the PLL.

Function
REQ-017 The FSM SHALL have states IDLE, ASSERT_RST, READ, WAIT_RD, WRITE, WAIT_WR, RELEASE, WAIT_LOCK.
REQ-018 IDLE: SEN=1 SHALL move to ASSERT_RST, clear the index to 0, clear ERR and set BUSY=1 and PLL_RST=1 on the same edge.
REQ-019 ASSERT_RST SHALL last exactly one cycle, then go to READ.
REQ-020 READ SHALL drive DEN=1, DWE=0 and DADDR=ADDR_TABLE[index] for exactly one cycle, then go to WAIT_RD.
REQ-021 WAIT_RD: on DRDY=1, DO SHALL be captured into a 16-bit read register and the FSM SHALL go to WRITE.
REQ-022 WRITE SHALL drive DEN=1, DWE=1, DADDR=ADDR_TABLE[index] and DI=(rd & MASK[index]) | (DATA[index] & ~MASK[index]) for exactly one cycle, then go to WAIT_WR.
REQ-023 WAIT_WR: on DRDY=1, if index==NUM_REGS-1 the FSM SHALL go to RELEASE; otherwise it SHALL increment the index and go to READ.
REQ-024 RELEASE SHALL drive PLL_RST=0 and go to WAIT_LOCK after one cycle.
REQ-025 WAIT_LOCK: LOCKED=1 SHALL produce SRDY=1 for exactly one cycle with BUSY=0 on the same edge and a return to IDLE.
REQ-026 DEN SHALL be high only in READ and WRITE; DWE SHALL be high only in WRITE.
REQ-027 At most one DRP transaction SHALL be outstanding.
REQ-028 DI and DADDR SHALL hold their last value outside READ and WRITE.
REQ-029 One 32-bit wait counter SHALL clear on entry to WAIT_RD, WAIT_WR and WAIT_LOCK and increment each cycle while in that state.
REQ-030 Timeout: the counter reaching DRDY_TIMEOUT in WAIT_RD or WAIT_WR, or LOCK_TIMEOUT in WAIT_LOCK, SHALL set ERR=1, BUSY=0 and PLL_RST=0 and return to IDLE; no SRDY pulse is issued.
REQ-031 Simultaneous events: DRDY or LOCKED arriving in the same cycle the counter reaches its limit SHALL count as success, not timeout.
REQ-032 SEN while BUSY=1 SHALL be ignored and SHALL NOT be queued.
REQ-033 DRDY outside WAIT_RD and WAIT_WR SHALL be ignored.
REQ-034 LOCKED outside WAIT_LOCK SHALL be ignored.

Reset
REQ-035 RSTN=0 at a rising DCLK edge SHALL force state IDLE and index=0, and SHALL set SRDY, BUSY, ERR, PLL_RST, DEN and DWE to 0 and DADDR and DI to 0.
REQ-036 Reset asserted mid-sequence SHALL abort the sequence at that edge with no SRDY pulse, and PLL_RST SHALL deassert.

Verification
REQ-037 NUM_REGS=2, addresses 0x08/0x09, masks 0x1000/0xFFFF, data 0x0041/0x0000, responder DO=0xFFFF, DRDY 2 cycles after DEN, LOCKED 10 cycles after PLL_RST falls -> writes DI=0x1041 @0x08 then DI=0xFFFF @0x09; one SRDY pulse; PLL_RST high during all DRP traffic.
REQ-038 Responder never asserts DRDY on the first read -> ERR=1 exactly 16 cycles after WAIT_RD entry; BUSY=0; PLL_RST=0; no WRITE issued.
REQ-039 LOCKED held 0 -> ERR=1 after 4096 cycles in WAIT_LOCK; a subsequent SEN clears ERR and restarts at index 0.
REQ-040 SEN pulsed every cycle during a run -> exactly one sequence and one SRDY pulse.
REQ-041 RSTN=0 in the cycle after the first WRITE -> all outputs at reset values on the next edge; no SRDY pulse.
REQ-042 DRDY arriving in the same cycle the counter reaches DRDY_TIMEOUT -> success path taken; ERR stays 0.

Source files
------------

// File: rtl/reconf_seq.sv
// reconf_seq: PLL dynamic-reconfiguration sequencer.
//
// On a start request this block holds the PLL in reset, read-modify-writes
// NUM_REGS DRP registers (address/mask/value tables supplied as parameters),
// releases the PLL reset and waits for LOCKED. Every wait on the PLL is
// bounded. A DRDY or lock timeout aborts the run and raises a sticky ERR flag.
//
// Ports
//   DCLK     in   sole clock, rising edge
//   RSTN     in   synchronous active-low reset
//   SEN      in   start request (ignored while BUSY)
//   SRDY     out  one-cycle pulse: reconfiguration done and PLL locked
//   BUSY     out  high from start acceptance until SRDY or ERR
//   ERR      out  sticky timeout flag, cleared by the next accepted start
//   PLL_RST  out  PLL reset
//   LOCKED   in   PLL lock indicator
//   DADDR    out  DRP address (holds its value outside READ/WRITE)
//   DEN      out  DRP enable
//   DWE      out  DRP write enable
//   DI       out  DRP write data (holds its value outside WRITE)
//   DO       in   DRP read data
//   DRDY     in   DRP transaction complete
module reconf_seq #(
  parameter int           NUM_REGS     = 2,
  parameter logic [55:0]  ADDR_TABLE   = 56'h0,
  parameter logic [127:0] MASK_TABLE   = 128'h0,
  parameter logic [127:0] DATA_TABLE   = 128'h0,
  parameter int           DRDY_TIMEOUT = 16,
  parameter int           LOCK_TIMEOUT = 4096
) (
  input  logic        DCLK,
  input  logic        RSTN,
  input  logic        SEN,
  output logic        SRDY,
  output logic        BUSY,
  output logic        ERR,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY
);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_RST,
    READ,
    WAIT_RD,
    WRITE,
    WAIT_WR,
    RELEASE,
    WAIT_LOCK
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NUM_REGS - 1);
  localparam logic [31:0] DRDY_LIM = 32'(DRDY_TIMEOUT);
  localparam logic [31:0] LOCK_LIM = 32'(LOCK_TIMEOUT);

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] wait_cnt;
  logic [31:0] wait_cnt_nxt;

  assign wait_cnt_nxt = wait_cnt + 32'd1;

  function automatic logic [6:0] addr_at(input logic [2:0] i);
    return ADDR_TABLE[int'(i)*7 +: 7];
  endfunction

  // Keep read-back bits where the mask is 1, take the table value elsewhere.
  function automatic logic [15:0] merge_at(input logic [2:0] i, input logic [15:0] rd);
    logic [15:0] m;
    logic [15:0] d;
    m = MASK_TABLE[int'(i)*16 +: 16];
    d = DATA_TABLE[int'(i)*16 +: 16];
    return (rd & m) | (d & ~m);
  endfunction

  // All outputs are registered: DEN/DWE/DADDR/DI are loaded on the edge that
  // enters READ or WRITE, so they are valid for exactly that state's cycle.
  // The read-back word is merged as it is captured from DO, so the DI
  // register itself serves as the read register for the following WRITE.
  // A DRDY/LOCKED seen in the same cycle the counter hits its limit is
  // tested first and therefore wins over the timeout.
  always_ff @(posedge DCLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      idx      <= 3'd0;
      wait_cnt <= 32'd0;
      SRDY     <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      PLL_RST  <= 1'b0;
      DEN      <= 1'b0;
      DWE      <= 1'b0;
      DADDR    <= 7'd0;
      DI       <= 16'd0;
    end else begin
      SRDY <= 1'b0;
      DEN  <= 1'b0;
      DWE  <= 1'b0;
      case (state)
        IDLE: begin
          if (SEN) begin
            state   <= ASSERT_RST;
            idx     <= 3'd0;
            ERR     <= 1'b0;
            BUSY    <= 1'b1;
            PLL_RST <= 1'b1;
          end
        end
        ASSERT_RST: begin
          state <= READ;
          DEN   <= 1'b1;
          DADDR <= addr_at(idx);
        end
        READ: begin
          state    <= WAIT_RD;
          wait_cnt <= 32'd0;
        end
        WAIT_RD: begin
          wait_cnt <= wait_cnt_nxt;
          if (DRDY) begin
            state <= WRITE;
            DEN   <= 1'b1;
            DWE   <= 1'b1;
            DADDR <= addr_at(idx);
            DI    <= merge_at(idx, DO);
          end else if (wait_cnt_nxt == DRDY_LIM) begin
            state   <= IDLE;
            ERR     <= 1'b1;
            BUSY    <= 1'b0;
            PLL_RST <= 1'b0;
          end
        end
        WRITE: begin
          state    <= WAIT_WR;
          wait_cnt <= 32'd0;
        end
        WAIT_WR: begin
          wait_cnt <= wait_cnt_nxt;
          if (DRDY) begin
            if (idx == LAST_IDX) begin
              state   <= RELEASE;
              PLL_RST <= 1'b0;
            end else begin
              idx   <= idx + 3'd1;
              state <= READ;
              DEN   <= 1'b1;
              DADDR <= addr_at(idx + 3'd1);
            end
          end else if (wait_cnt_nxt == DRDY_LIM) begin
            state   <= IDLE;
            ERR     <= 1'b1;
            BUSY    <= 1'b0;
            PLL_RST <= 1'b0;
          end
        end
        RELEASE: begin
          state    <= WAIT_LOCK;
          wait_cnt <= 32'd0;
        end
        WAIT_LOCK: begin
          wait_cnt <= wait_cnt_nxt;
          if (LOCKED) begin
            state <= IDLE;
            SRDY  <= 1'b1;
            BUSY  <= 1'b0;
          end else if (wait_cnt_nxt == LOCK_LIM) begin
            state   <= IDLE;
            ERR     <= 1'b1;
            BUSY    <= 1'b0;
            PLL_RST <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconf_seq.sv
// Scoreboard bench for reconf_seq: directed scenarios push the expected DRP
// reads/writes, SRDY pulses and ERR rises into a queue; a monitor pops and
// compares whenever the DUT presents one of those events.
module tb_reconf_seq;

  localparam int EV_RD   = 0;
  localparam int EV_WR   = 1;
  localparam int EV_SRDY = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic        DCLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        SEN = 1'b0;
  logic        LOCKED = 1'b0;
  logic        DRDY = 1'b0;
  logic [15:0] DO = 16'hFFFF;
  logic        SRDY, BUSY, ERR, PLL_RST, DEN, DWE;
  logic [6:0]  DADDR;
  logic [15:0] DI;

  ev_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  resp_en = 1;
  int  drdy_delay = 2;
  int  lock_en = 1;
  int  srdy_cnt = 0;
  int  t_den = 0;
  int  t_fall = 0;
  int  t_err = 0;

  reconf_seq #(
    .NUM_REGS    (2),
    .ADDR_TABLE  (56'h488),
    .MASK_TABLE  (128'hFFFF_1000),
    .DATA_TABLE  (128'h0000_0041),
    .DRDY_TIMEOUT(16),
    .LOCK_TIMEOUT(4096)
  ) dut (
    .DCLK   (DCLK),
    .RSTN   (RSTN),
    .SEN    (SEN),
    .SRDY   (SRDY),
    .BUSY   (BUSY),
    .ERR    (ERR),
    .PLL_RST(PLL_RST),
    .LOCKED (LOCKED),
    .DADDR  (DADDR),
    .DEN    (DEN),
    .DWE    (DWE),
    .DI     (DI),
    .DO     (DO),
    .DRDY   (DRDY)
  );

  always #5 DCLK = ~DCLK;
  always @(posedge DCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [6:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_regs();
    push(EV_RD, 7'h08, 16'h0000);
    push(EV_WR, 7'h08, 16'h1041);
    push(EV_RD, 7'h09, 16'h0000);
    push(EV_WR, 7'h09, 16'hFFFF);
  endtask

  task automatic got(input int kind, input logic [6:0] a, input logic [15:0] d);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h, required none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        mismatched++;
        $display("FAIL event actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // DRP responder: DO is constant 0xFFFF; DRDY pulses drdy_delay cycles after DEN.
  initial begin : drp_resp
    int pend;
    pend = 0;
    forever begin
      @(posedge DCLK);
      #1;
      DRDY = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) DRDY = 1'b1;
      end
      if (DEN === 1'b1 && resp_en != 0) pend = drdy_delay;
    end
  end

  // PLL model: LOCKED rises 10 cycles after PLL_RST falls, drops while in reset.
  initial begin : lock_resp
    int   pend;
    logic prev;
    pend = 0;
    prev = 1'b0;
    forever begin
      @(posedge DCLK);
      #1;
      if (PLL_RST === 1'b1) begin
        LOCKED = 1'b0;
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) LOCKED = 1'b1;
      end
      if (prev === 1'b1 && PLL_RST === 1'b0 && lock_en != 0) pend = 10;
      prev = PLL_RST;
    end
  end

  initial begin : monitor
    logic prev_err;
    logic prev_rst;
    prev_err = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge DCLK);
      if (DEN === 1'b1) begin
        chk("pll_rst_during_drp", PLL_RST, 1'b1);
        if (DWE === 1'b1) got(EV_WR, DADDR, DI);
        else begin
          got(EV_RD, DADDR, 16'h0000);
          t_den = cyc;
        end
      end else if (DWE === 1'b1) begin
        got(EV_WR, DADDR, DI);
      end
      if (SRDY === 1'b1) begin
        srdy_cnt++;
        got(EV_SRDY, 7'h00, 16'h0000);
      end
      if (ERR === 1'b1 && prev_err !== 1'b1) begin
        t_err = cyc;
        got(EV_ERR, 7'h00, 16'h0000);
      end
      if (prev_rst === 1'b1 && PLL_RST === 1'b0) t_fall = cyc;
      prev_err = ERR;
      prev_rst = PLL_RST;
    end
  end

  task automatic start_seq();
    SEN = 1'b1;
    @(posedge DCLK);
    #1;
    SEN = 1'b0;
    chk("start_busy", BUSY, 1'b1);
    chk("start_pll_rst", PLL_RST, 1'b1);
    chk("start_err_clr", ERR, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < budget) begin
      @(posedge DCLK);
      #1;
      n++;
    end
    chk("wait_idle_busy", BUSY, 1'b0);
    repeat (3) @(posedge DCLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_srdy"}, SRDY, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_err"}, ERR, 1'b0);
    chk({tag, "_pll_rst"}, PLL_RST, 1'b0);
    chk({tag, "_den"}, DEN, 1'b0);
    chk({tag, "_dwe"}, DWE, 1'b0);
    chk({tag, "_daddr"}, DADDR, 7'h00);
    chk({tag, "_di"}, DI, 16'h0000);
  endtask

  initial begin : main
    int s0;
    int n;
    // Reset state
    RSTN = 1'b0;
    repeat (3) @(posedge DCLK);
    #1;
    chk_reset_outputs("por");
    RSTN = 1'b1;
    repeat (2) @(posedge DCLK);
    #1;

    // Nominal two-register run
    s0 = srdy_cnt;
    push_regs();
    push(EV_SRDY, 7'h00, 16'h0000);
    start_seq();
    wait_idle(200);
    chk("nominal_srdy_count", srdy_cnt - s0, 1);
    chk("nominal_err", ERR, 1'b0);
    chk("hold_daddr", DADDR, 7'h09);
    chk("hold_di", DI, 16'hFFFF);

    // SEN held high during the run: one sequence only
    s0 = srdy_cnt;
    push_regs();
    push(EV_SRDY, 7'h00, 16'h0000);
    SEN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge DCLK);
      #1;
    end
    SEN = 1'b0;
    wait_idle(200);
    chk("sen_storm_srdy_count", srdy_cnt - s0, 1);

    // DRDY in the same cycle the counter reaches its limit: success
    drdy_delay = 16;
    s0 = srdy_cnt;
    push_regs();
    push(EV_SRDY, 7'h00, 16'h0000);
    start_seq();
    wait_idle(300);
    chk("edge_drdy_err", ERR, 1'b0);
    chk("edge_drdy_srdy_count", srdy_cnt - s0, 1);
    drdy_delay = 2;

    // DRDY never arrives on the first read
    resp_en = 0;
    push(EV_RD, 7'h08, 16'h0000);
    push(EV_ERR, 7'h00, 16'h0000);
    start_seq();
    wait_idle(100);
    chk("drdy_timeout_latency", t_err - t_den, 17);
    chk("drdy_timeout_err", ERR, 1'b1);
    chk("drdy_timeout_pll_rst", PLL_RST, 1'b0);
    resp_en = 1;
    repeat (20) @(posedge DCLK);
    #1;

    // LOCKED never arrives
    lock_en = 0;
    push_regs();
    push(EV_ERR, 7'h00, 16'h0000);
    start_seq();
    wait_idle(5000);
    chk("lock_timeout_latency", t_err - t_fall, 4097);
    chk("lock_timeout_err", ERR, 1'b1);
    chk("lock_timeout_pll_rst", PLL_RST, 1'b0);
    lock_en = 1;

    // Restart after error clears ERR and begins at index 0
    s0 = srdy_cnt;
    push_regs();
    push(EV_SRDY, 7'h00, 16'h0000);
    start_seq();
    wait_idle(200);
    chk("restart_srdy_count", srdy_cnt - s0, 1);

    // Reset in the cycle after the first WRITE
    s0 = srdy_cnt;
    push(EV_RD, 7'h08, 16'h0000);
    push(EV_WR, 7'h08, 16'h1041);
    start_seq();
    n = 0;
    while (!(DEN === 1'b1 && DWE === 1'b1) && n < 50) begin
      @(posedge DCLK);
      #1;
      n++;
    end
    chk("saw_first_write", {DEN, DWE}, 2'b11);
    @(posedge DCLK);
    #1;
    RSTN = 1'b0;
    @(posedge DCLK);
    #1;
    chk_reset_outputs("mid_rst");
    RSTN = 1'b1;
    repeat (30) @(posedge DCLK);
    #1;
    chk("mid_rst_no_srdy", srdy_cnt - s0, 0);
    chk("mid_rst_idle", BUSY, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
